// File: rtl/cache_req_sequencer.sv
// cache_req_sequencer: buffers producer commands in a small FIFO and issues
// them one at a time to the cache over a 4-phase request/valid handshake,
// returning one response per command (data, evict flag, timeout flag).
module cache_req_sequencer #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 8,
  parameter int OP_W    = 4,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic              cmd_write,
  output logic [OP_W-1:0]   cache_operation,
  output logic [ADDR_W-1:0] cache_addr,
  output logic [DATA_W-1:0] cache_data_out,
  output logic              cache_data_oe,
  input  logic [DATA_W-1:0] cache_data_in,
  output logic              cache_request,
  input  logic              cache_valid,
  input  logic              cache_evict,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_evict,
  output logic              rsp_timeout,
  output logic [15:0]       evict_count,
  output logic              busy
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              write;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK} state_e;

  cmd_t             fifo_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             full, empty, push, pop;
  cmd_t             head;

  state_e            state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              req_q, req_d, oe_q, oe_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              rsp_valid_q, rsp_valid_d, rsp_evict_q, rsp_evict_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [15:0]       evict_count_q, evict_count_d;

  assign full      = (count_q == (PTR_W+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign head      = fifo_mem[rd_ptr_q];

  // FIFO storage: contents need no reset, the pointers define validity
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= '{op: cmd_op, addr: cmd_addr, wdata: cmd_wdata, write: cmd_write};
  end

  // FIFO pointer/occupancy next state; push and pop together leave count alone
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = PTR_W'(wr_ptr_q + 1'b1);
    if (pop)  rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Handshake FSM: next state, cache drive fields, response capture
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    req_d         = req_q;
    oe_d          = oe_q;
    op_d          = op_q;
    addr_d        = addr_q;
    dout_d        = dout_q;
    rsp_valid_d   = 1'b0;
    rsp_data_d    = rsp_data_q;
    rsp_evict_d   = rsp_evict_q;
    rsp_timeout_d = rsp_timeout_q;
    evict_count_d = evict_count_q;
    pop           = 1'b0;
    case (state_q)
      S_IDLE: begin
        // a still-high valid is a leftover acknowledge; wait it out
        if (!empty && !cache_valid) begin
          pop     = 1'b1;
          op_d    = head.op;
          addr_d  = head.addr;
          dout_d  = head.wdata;
          oe_d    = head.write;
          req_d   = 1'b1;
          timer_d = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (cache_valid) begin
          rsp_valid_d   = 1'b1;
          rsp_data_d    = cache_data_in;
          rsp_evict_d   = cache_evict;
          rsp_timeout_d = 1'b0;
          req_d         = 1'b0;
          oe_d          = 1'b0;
          state_d       = S_ACK;
          if (cache_evict && (evict_count_q != 16'hFFFF))
            evict_count_d = evict_count_q + 16'd1;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          // last waiting cycle: request has been held TIMEOUT cycles
          rsp_valid_d   = 1'b1;
          rsp_data_d    = '0;
          rsp_evict_d   = 1'b0;
          rsp_timeout_d = 1'b1;
          req_d         = 1'b0;
          oe_d          = 1'b0;
          state_d       = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_ACK: begin
        req_d = 1'b0;
        if (!cache_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM and registered output flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      req_q         <= 1'b0;
      oe_q          <= 1'b0;
      op_q          <= '0;
      addr_q        <= '0;
      dout_q        <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_evict_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      evict_count_q <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      req_q         <= req_d;
      oe_q          <= oe_d;
      op_q          <= op_d;
      addr_q        <= addr_d;
      dout_q        <= dout_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_evict_q   <= rsp_evict_d;
      rsp_timeout_q <= rsp_timeout_d;
      evict_count_q <= evict_count_d;
    end
  end

  assign cache_operation = op_q;
  assign cache_addr      = addr_q;
  assign cache_data_out  = dout_q;
  assign cache_data_oe   = oe_q;
  assign cache_request   = req_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_data        = rsp_data_q;
  assign rsp_evict       = rsp_evict_q;
  assign rsp_timeout     = rsp_timeout_q;
  assign evict_count     = evict_count_q;
  assign busy            = (state_q != S_IDLE) || !empty;

endmodule

// File: tb/tb_cache_req_sequencer.sv
// Bench for cache_req_sequencer: table of single transactions, hand-written
// multi-cycle sequences, and randomized traffic against a cache responder
// plus a queue-based scoreboard.
module tb_cache_req_sequencer;
  localparam int TO = 8;

  logic        clk, rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [3:0]  cmd_op;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic [3:0]  cache_operation;
  logic [31:0] cache_addr;
  logic [7:0]  cache_data_out, cache_data_in, rsp_data;
  logic        cache_data_oe, cache_request, cache_valid, cache_evict;
  logic        rsp_valid, rsp_evict, rsp_timeout, busy;
  logic [15:0] evict_count;
  logic        bfm_valid, man_valid;

  assign cache_valid = bfm_valid | man_valid;

  cache_req_sequencer #(.ADDR_W(32), .DATA_W(8), .OP_W(4), .DEPTH(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_write(cmd_write),
    .cache_operation(cache_operation), .cache_addr(cache_addr), .cache_data_out(cache_data_out),
    .cache_data_oe(cache_data_oe), .cache_data_in(cache_data_in), .cache_request(cache_request),
    .cache_valid(cache_valid), .cache_evict(cache_evict),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_evict(rsp_evict), .rsp_timeout(rsp_timeout),
    .evict_count(evict_count), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [7:0]  wdata;
    logic        write;
  } cmd_t;

  typedef struct {
    logic [7:0] data;
    logic       evict;
    logic       timeout;
    int         len;
  } rsp_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [7:0]  wdata;
    logic        write;
    int          lat;
    logic [7:0]  rdata;
    logic        evict;
    logic [7:0]  exp_data;
    logic        exp_evict;
    logic        exp_timeout;
    logic [15:0] exp_ec;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  cmd_t exp_cmd[$];
  rsp_t exp_rsp[$];
  logic [15:0] model_ec = 16'h0;

  // cache responder configuration
  bit         bfm_rand = 0;
  int         bfm_lat  = 2;
  int         bfm_hold = 0;
  logic [7:0] bfm_rdata = 8'h0;
  logic       bfm_evict = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input cmd_t c);
    int w = 0;
    cmd_valid = 1'b1; cmd_op = c.op; cmd_addr = c.addr; cmd_wdata = c.wdata; cmd_write = c.write;
    while (!cmd_ready && w < 200) begin tick(); w++; end
    if (w >= 200) bound_fail("push_ready");
    else exp_cmd.push_back(c);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string nm);
    int w = 0;
    while (!rsp_valid && w < 100) begin tick(); w++; end
    if (w >= 100) bound_fail(nm);
  endtask

  task automatic wait_idle(input string nm);
    int w = 0;
    while ((busy || cache_valid) && w < 400) begin tick(); w++; end
    if (w >= 400) bound_fail(nm);
  endtask

  // Cache responder: answers each new request after a chosen latency and
  // records what the sequencer must report for it.
  initial begin : cache_bfm
    int cnt, lat, hold;
    bit active, acked;
    logic [7:0] d;
    logic e;
    rsp_t r;
    bfm_valid = 1'b0; cache_evict = 1'b0; cache_data_in = 8'h0;
    active = 0; acked = 0; cnt = 0; lat = 0; hold = 0; d = 8'h0; e = 1'b0;
    forever begin
      tick();
      if (!rst_n) begin
        bfm_valid = 1'b0; cache_evict = 1'b0; active = 0;
        continue;
      end
      if (!active && cache_request && !cache_valid) begin
        active = 1; acked = 0; cnt = 0;
        if (bfm_rand) begin
          lat = $urandom_range(1, TO + 2); hold = $urandom_range(0, 2);
          d = 8'($urandom); e = 1'($urandom_range(0, 1));
        end else begin
          lat = bfm_lat; hold = bfm_hold; d = bfm_rdata; e = bfm_evict;
        end
        if (lat > TO) r = '{8'h0, 1'b0, 1'b1, TO};
        else          r = '{d, e, 1'b0, lat};
        exp_rsp.push_back(r);
      end
      if (active) begin
        if (!acked) begin
          if (!cache_request) active = 0;
          else begin
            cnt++;
            if (cnt >= lat) begin
              bfm_valid = 1'b1; cache_data_in = d; cache_evict = e; acked = 1;
            end
          end
        end else if (!cache_request) begin
          if (hold == 0) begin
            bfm_valid = 1'b0; cache_evict = 1'b0; active = 0;
          end else hold--;
        end
      end
    end
  end

  // Scoreboard: command order/fields at each request, request length,
  // response contents, spacing of request starts, eviction count.
  initial begin : monitor
    bit   prev_req;
    int   len, tk, last_rise;
    cmd_t cur;
    rsp_t r;
    prev_req = 0; len = 0; tk = 0; last_rise = -100;
    cur = '{4'h0, 32'h0, 8'h0, 1'b0};
    forever begin
      tick();
      tk++;
      if (!rst_n) begin prev_req = 0; continue; end
      if (cache_request && !prev_req) begin
        if (exp_cmd.size() == 0) bound_fail("unexpected_request");
        else begin
          cur = exp_cmd.pop_front();
          chk("req_op", cache_operation, cur.op);
          chk("req_addr", cache_addr, cur.addr);
        end
        chk("req_spacing_ge3", (tk - last_rise) >= 3, 1);
        last_rise = tk;
        len = 0;
      end
      if (cache_request) begin
        len++;
        chk("oe_during_req", cache_data_oe, cur.write);
        if (cur.write) chk("data_out_during_req", cache_data_out, cur.wdata);
        chk("addr_stable", cache_addr, cur.addr);
      end else begin
        chk("oe_idle", cache_data_oe, 0);
      end
      if (!cache_request && prev_req) begin
        chk("rsp_with_req_fall", rsp_valid, 1);
        chk("addr_held_after", cache_addr, cur.addr);
        if (exp_rsp.size() == 0) bound_fail("missing_expected_rsp");
        else begin
          r = exp_rsp.pop_front();
          chk("req_high_len", len, r.len);
          chk("rsp_data", rsp_data, r.data);
          chk("rsp_evict", rsp_evict, r.evict);
          chk("rsp_timeout", rsp_timeout, r.timeout);
          if (r.evict && model_ec != 16'hFFFF) model_ec = model_ec + 16'd1;
          chk("evict_count", evict_count, model_ec);
        end
      end else if (rsp_valid) begin
        chk("spurious_rsp", rsp_valid, 0);
      end
      prev_req = cache_request;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  vec_t vecs[7];
  cmd_t c;

  initial begin : main
    int n, w;
    vecs[0] = '{4'h1, 32'h0000_0100, 8'h00, 1'b0, 2,      8'hA5, 1'b0, 8'hA5, 1'b0, 1'b0, 16'd0};
    vecs[1] = '{4'h2, 32'h0000_0200, 8'h3C, 1'b1, 3,      8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 16'd1};
    vecs[2] = '{4'hF, 32'hFFFF_FFFF, 8'h00, 1'b0, 1,      8'hFF, 1'b0, 8'hFF, 1'b0, 1'b0, 16'd1};
    vecs[3] = '{4'h3, 32'h0000_0040, 8'h81, 1'b1, TO,     8'h5A, 1'b1, 8'h5A, 1'b1, 1'b0, 16'd2};
    vecs[4] = '{4'h4, 32'h0000_0044, 8'h00, 1'b0, TO + 1, 8'h77, 1'b1, 8'h00, 1'b0, 1'b1, 16'd2};
    vecs[5] = '{4'h0, 32'h0000_0000, 8'h00, 1'b0, 20,     8'h99, 1'b1, 8'h00, 1'b0, 1'b1, 16'd2};
    vecs[6] = '{4'h7, 32'h0000_1234, 8'h00, 1'b1, 5,      8'h12, 1'b0, 8'h12, 1'b0, 1'b0, 16'd2};

    rst_n = 1'b0; man_valid = 1'b0;
    cmd_valid = 1'b0; cmd_op = 4'h0; cmd_addr = 32'h0; cmd_wdata = 8'h0; cmd_write = 1'b0;
    tick(); tick();
    chk("rst_request", cache_request, 0);
    chk("rst_oe", cache_data_oe, 0);
    chk("rst_op", cache_operation, 0);
    chk("rst_addr", cache_addr, 0);
    chk("rst_dout", cache_data_out, 0);
    chk("rst_rsp", {rsp_valid, rsp_data, rsp_evict, rsp_timeout}, 0);
    chk("rst_evict_count", evict_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    rst_n = 1'b1;
    tick();

    // single transactions
    for (int i = 0; i < 7; i++) begin
      bfm_rand = 0; bfm_lat = vecs[i].lat; bfm_hold = 1;
      bfm_rdata = vecs[i].rdata; bfm_evict = vecs[i].evict;
      push('{vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].write});
      wait_rsp("vec_rsp");
      chk("vec_rsp_data", rsp_data, vecs[i].exp_data);
      chk("vec_rsp_evict", rsp_evict, vecs[i].exp_evict);
      chk("vec_rsp_timeout", rsp_timeout, vecs[i].exp_timeout);
      chk("vec_evict_count", evict_count, vecs[i].exp_ec);
      wait_idle("vec_idle");
    end

    // fill / backpressure: 4 queued plus 1 in flight
    bfm_rand = 0; bfm_lat = 7; bfm_hold = 0; bfm_rdata = 8'h11; bfm_evict = 1'b0;
    for (int i = 0; i < 5; i++) push('{4'(i), 32'h1000 + 32'(i), 8'h0, 1'b0});
    chk("full_cmd_ready", cmd_ready, 0);
    chk("full_busy", busy, 1);
    n = 0; w = 0;
    while (n < 5 && w < 300) begin
      if (rsp_valid) n++;
      tick(); w++;
    end
    chk("fill_rsp_count", n, 5);
    wait_idle("fill_idle");

    // timeout, then a late 3-cycle valid that must hold off the next request
    bfm_lat = 100;
    push('{4'h5, 32'hDEAD_0000, 8'h0, 1'b0});
    w = 0;
    while (!cache_request && w < 20) begin tick(); w++; end
    tick();
    bfm_lat = 2; bfm_rdata = 8'h6B;
    push('{4'h6, 32'hBEEF_0000, 8'h0, 1'b0});
    wait_rsp("timeout_rsp");
    chk("timeout_flag", rsp_timeout, 1);
    chk("timeout_data", rsp_data, 0);
    chk("timeout_req_low", cache_request, 0);
    man_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); chk("late_valid_blocks", cache_request, 0); end
    man_valid = 1'b0;
    tick();
    chk("req_after_late_valid", cache_request, 1);
    wait_idle("late_idle");

    // randomized traffic
    bfm_rand = 1;
    for (int i = 0; i < 40; i++) begin
      c = '{4'($urandom), $urandom, 8'($urandom), 1'($urandom_range(0, 1))};
      push(c);
      repeat ($urandom_range(0, 3)) tick();
    end
    wait_idle("rand_idle");
    chk("rand_all_consumed", exp_cmd.size() + exp_rsp.size(), 0);

    // saturation of the eviction counter
    bfm_rand = 0; bfm_lat = 2; bfm_hold = 0; bfm_evict = 1'b1; bfm_rdata = 8'h42;
    force dut.evict_count_q = 16'hFFFE;
    model_ec = 16'hFFFE;
    tick();
    release dut.evict_count_q;
    tick();
    for (int i = 0; i < 2; i++) begin
      push('{4'h9, 32'h0000_9000, 8'h0, 1'b0});
      wait_rsp("sat_rsp");
      chk("sat_evict_count", evict_count, 16'hFFFF);
      wait_idle("sat_idle");
    end

    // reset with a request in flight and two commands queued
    bfm_lat = 6; bfm_evict = 1'b0;
    for (int i = 0; i < 3; i++) push('{4'hA, 32'h0000_A000 + 32'(i), 8'h0, 1'b0});
    chk("pre_reset_request", cache_request, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_request", cache_request, 0);
    chk("mid_rst_outputs", {cache_data_oe, cache_operation, cache_addr, cache_data_out}, 0);
    chk("mid_rst_rsp", {rsp_valid, rsp_timeout, rsp_evict, evict_count}, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    exp_cmd.delete(); exp_rsp.delete(); model_ec = 16'h0;
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("post_rst_no_request", cache_request, 0);
    bfm_lat = 2; bfm_rdata = 8'hC3;
    push('{4'hB, 32'h0000_B000, 8'h0, 1'b0});
    wait_rsp("post_rst_rsp");
    chk("post_rst_rsp_data", rsp_data, 8'hC3);
    wait_idle("post_rst_idle");
    chk("final_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
